// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared widths, reset vector and state encodings for pc_fetch
package pc_fetch_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_inc16.sv
// rtl/pc_fetch_inc16.sv - wrapping incrementer used as the sequential pc+1 path
module inc16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = a + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - Hack CPU fetch stage: owns pc, drives ROM address, presents instr over valid/ready
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int               WIDTH        = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  output logic [WIDTH-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] pc_inc;

  inc16 #(.WIDTH(WIDTH)) u_inc16 (
    .a (pc_q),
    .y (pc_inc)
  );

  assign rom_addr = pc_q;

  // Output mux depends only on registered state, so ready/jump never reach instr/instr_valid.
  always_comb begin
    instr       = '0;
    instr_pc    = '0;
    instr_valid = 1'b0;
    case (state_q)
      STREAM: begin
        instr       = rom_data;
        instr_pc    = fetch_pc_q;
        instr_valid = 1'b1;
      end
      HOLD: begin
        instr       = hold_q;
        instr_pc    = fetch_pc_q;
        instr_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    hold_d     = hold_q;
    if (jump) begin
      pc_d    = jump_addr;
      hold_d  = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          fetch_pc_d = pc_q;
          pc_d       = pc_inc;
          state_d    = STREAM;
        end
        STREAM: begin
          if (instr_ready) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_inc;
          end else begin
            // pc was already advanced when this word issued; the ROM keeps re-reading it.
            hold_d  = rom_data;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_inc;
            state_d    = STREAM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      fetch_pc_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed table-driven bench for pc_fetch with a 1-cycle ROM model
module tb_pc_fetch;

  logic        clk;
  logic        reset;
  logic        jump;
  logic [15:0] jump_addr;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  pc_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  always @(posedge clk) rom_data <= mem(rom_addr);

  typedef struct {
    logic        rst;
    logic        jmp;
    logic [15:0] jaddr;
    logic        rdy;
    logic        ev;
    logic        full;
    logic [15:0] epc;
    logic [15:0] era;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic jmp, input logic [15:0] jaddr,
                              input logic rdy, input logic ev, input logic full,
                              input logic [15:0] epc, input logic [15:0] era);
    vec_t v;
    v.rst = rst; v.jmp = jmp; v.jaddr = jaddr; v.rdy = rdy;
    v.ev = ev; v.full = full; v.epc = epc; v.era = era;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // rst jmp jaddr rdy | ev full epc era   (each row = one cycle's inputs and observed outputs)
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,16'h0000,16'h0000));  // first cycle after reset
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0000,16'h0001));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0001,16'h0002));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0002,16'h0003));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0003,16'h0004));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0004,16'h0005));
    vecs.push_back(mk(0,0,16'h0000,0, 1,0,16'h0005,16'h0006));  // ready drops at pc 5
    vecs.push_back(mk(0,0,16'h0000,0, 1,0,16'h0005,16'h0006));
    vecs.push_back(mk(0,0,16'h0000,0, 1,0,16'h0005,16'h0006));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0005,16'h0006));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0006,16'h0007));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0007,16'h0008));
    vecs.push_back(mk(0,1,16'h0100,1, 1,0,16'h0008,16'h0009));  // jump to 0x0100
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,16'h0000,16'h0100));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0100,16'h0101));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0101,16'h0102));
    vecs.push_back(mk(0,0,16'h0000,0, 1,0,16'h0102,16'h0103));
    vecs.push_back(mk(0,1,16'h0020,0, 1,0,16'h0102,16'h0103));  // jump from HOLD
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,16'h0000,16'h0020));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0020,16'h0021));
    vecs.push_back(mk(0,1,16'hFFFE,1, 1,0,16'h0021,16'h0022));  // jump near top of space
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,16'h0000,16'hFFFE));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'hFFFE,16'hFFFF));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'hFFFF,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0000,16'h0001));
    vecs.push_back(mk(0,0,16'h0000,0, 1,0,16'h0001,16'h0002));
    vecs.push_back(mk(1,1,16'h1234,0, 1,0,16'h0001,16'h0002));  // reset + jump in HOLD
    vecs.push_back(mk(0,0,16'h0000,1, 0,1,16'h0000,16'h0000));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0000,16'h0001));
    vecs.push_back(mk(0,1,16'h0040,0, 1,0,16'h0001,16'h0002));  // jump with ready low drops word
    vecs.push_back(mk(0,0,16'h0000,1, 0,0,16'h0000,16'h0040));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0040,16'h0041));
    vecs.push_back(mk(0,0,16'h0000,1, 1,0,16'h0041,16'h0042));

    reset = 1'b1; jump = 1'b0; jump_addr = '0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; jump = vecs[i].jmp; jump_addr = vecs[i].jaddr; instr_ready = vecs[i].rdy;
      #1;
      check($sformatf("row%0d valid", i), {15'd0, instr_valid}, {15'd0, vecs[i].ev});
      check($sformatf("row%0d rom_addr", i), rom_addr, vecs[i].era);
      if (vecs[i].ev || vecs[i].full) begin
        check($sformatf("row%0d instr_pc", i), instr_pc, vecs[i].epc);
        check($sformatf("row%0d instr", i), instr, vecs[i].ev ? mem(vecs[i].epc) : 16'h0000);
      end
    end

    // Long hold with ready/jump glitching inside the cycle: outputs must not follow them.
    @(negedge clk); reset = 1'b1; jump = 1'b0; instr_ready = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); instr_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      check("hold valid", {15'd0, instr_valid}, 16'd1);
      check("hold instr_pc", instr_pc, 16'h0000);
      check("hold instr", instr, mem(16'h0000));
      instr_ready = 1'b1; jump = 1'b1; jump_addr = 16'hBEEF;
      #1;
      check("glitch instr", instr, mem(16'h0000));
      check("glitch valid", {15'd0, instr_valid}, 16'd1);
      instr_ready = 1'b0; jump = 1'b0; jump_addr = 16'h0000;
    end
    @(negedge clk); instr_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #1;
      check("resume instr_pc", instr_pc, 16'(k));
      check("resume instr", instr, mem(16'(k)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
